tdd_frame_timer: RTL

//  Sample-rate frame timer fed by the AXI2S control register file. Counts samples within a radio

---
 rtl/tdd_frame_timer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tdd_frame_timer.sv
// Sample-rate radio frame timer with one-shot length adjustment and TDD/FDD TX/RX windows.
// Optional timestamp capture port (ts_req/ts_val) when TIMER_STAMP_EN is defined.
module tdd_frame_timer #(
    parameter int unsigned CW  = 24,
    parameter int unsigned FCW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              sample_tick,
    input  logic              tddmode,
    input  logic [CW-1:0]     frame_len,
    input  logic [CW-1:0]     frame_adj,
    input  logic              adj_req,
    input  logic [CW-1:0]     tstart,
    input  logic [CW-1:0]     tend,
    input  logic [CW-1:0]     rstart,
    input  logic [CW-1:0]     rend,
`ifdef TIMER_STAMP_EN
    input  logic              ts_req,
    output logic [FCW+CW-1:0] ts_val,
`endif
    output logic [CW-1:0]     sample_cnt,
    output logic [FCW-1:0]    frame_cnt,
    output logic              frame_start,
    output logic              tx_win,
    output logic              rx_win,
    output logic              adj_pending
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    sample_cnt_q, sample_cnt_d;
    logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CW-1:0]    cur_len_q, cur_len_d;
    logic [CW-1:0]    adj_off_q, adj_off_d;
    logic             adj_pending_q, adj_pending_d;
    logic             frame_start_q, frame_start_d;
    logic             tx_win_q, tx_win_d;
    logic             rx_win_q, rx_win_d;

    logic             len_latch;
    logic [CW+1:0]    adj_sum;
    logic [CW-1:0]    adj_len;
    logic [CW-1:0]    nom_len;
    logic [CW-1:0]    next_len;

    // Inclusive window; start > end means the window wraps through the frame boundary.
    function automatic logic in_win(input logic [CW-1:0] c, input logic [CW-1:0] s,
                                    input logic [CW-1:0] e);
        if (s <= e)
            return (c >= s) && (c <= e);
        else
            return (c >= s) || (c <= e);
    endfunction

    // Two guard bits keep the sum exact for every frame_len/offset pair before clamping.
    always_comb begin
        adj_sum = {2'b00, frame_len} + {{2{adj_off_q[CW-1]}}, adj_off_q};
        if (adj_sum[CW+1] || (adj_sum == '0))
            adj_len = CW'(1);
        else if (adj_sum[CW])
            adj_len = '1;
        else
            adj_len = adj_sum[CW-1:0];
        nom_len  = (frame_len == '0) ? CW'(1) : frame_len;
        next_len = adj_pending_q ? adj_len : nom_len;
    end

    always_comb begin
        state_d       = state_q;
        sample_cnt_d  = sample_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        cur_len_d     = cur_len_q;
        adj_off_d     = adj_off_q;
        adj_pending_d = adj_pending_q;
        frame_start_d = 1'b0;
        len_latch     = 1'b0;

        tx_win_d = run && (state_q == ST_RUN) && (!tddmode || in_win(sample_cnt_q, tstart, tend));
        rx_win_d = run && (state_q == ST_RUN) && (!tddmode || in_win(sample_cnt_q, rstart, rend));

        if (!run) begin
            state_d      = ST_IDLE;
            sample_cnt_d = '0;
        end else if (sample_tick) begin
            if (state_q == ST_IDLE) begin
                state_d       = ST_RUN;
                sample_cnt_d  = '0;
                frame_start_d = 1'b1;
                len_latch     = 1'b1;
            end else if (sample_cnt_q == cur_len_q - CW'(1)) begin
                sample_cnt_d  = '0;
                frame_start_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + FCW'(1);
                len_latch     = 1'b1;
            end else begin
                sample_cnt_d  = sample_cnt_q + CW'(1);
            end
        end

        if (len_latch) begin
            cur_len_d     = next_len;
            adj_pending_d = 1'b0;
        end
        // A request on the latch cycle re-arms for the following boundary.
        if (adj_req) begin
            adj_off_d     = frame_adj;
            adj_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sample_cnt_q  <= '0;
            frame_cnt_q   <= '0;
            cur_len_q     <= CW'(1);
            adj_off_q     <= '0;
            adj_pending_q <= 1'b0;
            frame_start_q <= 1'b0;
            tx_win_q      <= 1'b0;
            rx_win_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_cnt_q  <= sample_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            cur_len_q     <= cur_len_d;
            adj_off_q     <= adj_off_d;
            adj_pending_q <= adj_pending_d;
            frame_start_q <= frame_start_d;
            tx_win_q      <= tx_win_d;
            rx_win_q      <= rx_win_d;
        end
    end

    assign sample_cnt  = sample_cnt_q;
    assign frame_cnt   = frame_cnt_q;
    assign frame_start = frame_start_q;
    assign tx_win      = tx_win_q;
    assign rx_win      = rx_win_q;
    assign adj_pending = adj_pending_q;

`ifdef TIMER_STAMP_EN
    logic [FCW+CW-1:0] ts_val_q, ts_val_d;

    always_comb begin
        ts_val_d = ts_req ? {frame_cnt_q, sample_cnt_q} : ts_val_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ts_val_q <= '0;
        else
            ts_val_q <= ts_val_d;
    end

    assign ts_val = ts_val_q;
`endif

endmodule
